// File: rtl/skinny_sbox8_dom1_np_core.sv
// First-order DOM-masked (2-share) SKINNY-128 8-bit S-box, non-pipelined.
// Four nonlinear rounds in series; each round registers only its DOM cross terms.
module skinny_sbox8_dom1_np_core (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] so_1,
  output logic [7:0] so_0,
  input  logic [7:0] si_1,
  input  logic [7:0] si_0,
  input  logic [7:0] r
);

  // One bit per round. Gate "x4" updates bit 4 and gate "x0" updates bit 0.
  logic [3:0] r_x4_s0, r_x4_s1, r_x0_s0, r_x0_s1;
  logic [3:0] w_x4_cr0, w_x4_cr1, w_x0_cr0, w_x0_cr1;

  function automatic logic [7:0] perm_round(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  function automatic logic [7:0] perm_last(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  // NOTE: combinational logic uses blocking assignments, and every variable
  // gets a value before it is read, so no latch can be inferred.
  always_comb begin
    logic [7:0] v_s0, v_s1;
    logic       a0, b0, a1, b1, c0, c1;
    logic       d0, e0, d1, e1, f0, f1;
    w_x4_cr0 = '0;
    w_x4_cr1 = '0;
    w_x0_cr0 = '0;
    w_x0_cr1 = '0;
    v_s0 = si_0;
    v_s1 = si_1;
    for (int k = 0; k < 4; k++) begin
      // NOR(a,b) = AND(~a,~b): the complement lands on share 0 only.
      a0 = ~v_s0[7];
      b0 = ~v_s0[6];
      a1 = v_s1[7];
      b1 = v_s1[6];
      d0 = ~v_s0[3];
      e0 = ~v_s0[2];
      d1 = v_s1[3];
      e1 = v_s1[2];
      w_x4_cr0[k] = (a0 & b1) ^ r[2*k];
      w_x4_cr1[k] = (a1 & b0) ^ r[2*k];
      w_x0_cr0[k] = (d0 & e1) ^ r[2*k+1];
      w_x0_cr1[k] = (d1 & e0) ^ r[2*k+1];
      c0 = (a0 & b0) ^ r_x4_s0[k];
      c1 = (a1 & b1) ^ r_x4_s1[k];
      f0 = (d0 & e0) ^ r_x0_s0[k];
      f1 = (d1 & e1) ^ r_x0_s1[k];
      v_s0[4] = v_s0[4] ^ c0;
      v_s0[0] = v_s0[0] ^ f0;
      v_s1[4] = v_s1[4] ^ c1;
      v_s1[0] = v_s1[0] ^ f1;
      if (k < 3) begin
        v_s0 = perm_round(v_s0);
        v_s1 = perm_round(v_s1);
      end else begin
        v_s0 = perm_last(v_s0);
        v_s1 = perm_last(v_s1);
      end
    end
    so_0 = v_s0;
    so_1 = v_s1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x4_s0 <= '0;
      r_x4_s1 <= '0;
      r_x0_s0 <= '0;
      r_x0_s1 <= '0;
    end else begin
      r_x4_s0 <= w_x4_cr0;
      r_x4_s1 <= w_x4_cr1;
      r_x0_s0 <= w_x0_cr0;
      r_x0_s1 <= w_x0_cr1;
    end
  end

endmodule

// File: tb/tb_skinny_sbox8_dom1_np_core.sv
// Self-checking bench for the masked S8 core: directed table, share-level
// reset/latency sequences and a back-to-back sweep of all 256 inputs.
module tb_skinny_sbox8_dom1_np_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] so_1, so_0, si_1, si_0, r;
  int         n_checks = 0;
  int         n_errors = 0;

  typedef struct {
    logic [7:0] si;
    logic [7:0] mask;
    logic [7:0] rnd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  skinny_sbox8_dom1_np_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .so_1  (so_1),
    .so_0  (so_0),
    .si_1  (si_1),
    .si_0  (si_0),
    .r     (r)
  );

  always #5 clk = ~clk;

  // Unmasked S8 golden model.
  function automatic logic [7:0] s8_ref(input logic [7:0] x_in);
    logic [7:0] x;
    x = x_in;
    for (int k = 0; k < 4; k++) begin
      x[4] = x[4] ^ ~(x[7] | x[6]);
      x[0] = x[0] ^ ~(x[3] | x[2]);
      if (k < 3) x = {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
      else       x = {x[7:3], x[1], x[2], x[0]};
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] si, input logic [7:0] m, input logic [7:0] rr);
    si_0 = si ^ m;
    si_1 = m;
    r    = rr;
  endtask

  // Called at a negedge: drive, hold for 4 posedges, sample at the next negedge.
  task automatic run_vec(input string name, input logic [7:0] si, input logic [7:0] m,
                         input logic [7:0] rr, input logic [7:0] exp);
    drive(si, m, rr);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(name, so_0 ^ so_1, exp);
  endtask

  initial begin
    int sweep_err;
    vecs[0]  = '{8'h00, 8'h00, 8'h00, 8'h65};
    vecs[1]  = '{8'h01, 8'h00, 8'h00, 8'h4C};
    vecs[2]  = '{8'h02, 8'h00, 8'h00, 8'h6A};
    vecs[3]  = '{8'h0F, 8'h00, 8'h00, 8'h7B};
    vecs[4]  = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vecs[5]  = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    vecs[6]  = '{8'h00, 8'hFF, 8'h00, 8'h65};
    vecs[7]  = '{8'h02, 8'hFF, 8'hFF, 8'h6A};
    vecs[8]  = '{8'h01, 8'hA5, 8'hFF, 8'h4C};
    vecs[9]  = '{8'h3C, 8'hA5, 8'h00, s8_ref(8'h3C)};
    vecs[10] = '{8'h3C, 8'hA5, 8'h55, s8_ref(8'h3C)};
    vecs[11] = '{8'h3C, 8'hA5, 8'hAA, s8_ref(8'h3C)};
    vecs[12] = '{8'h3C, 8'hA5, 8'hFF, s8_ref(8'h3C)};

    rst_n = 1'b0;
    drive(8'h00, 8'h00, 8'h00);
    #1;
    // Flops cleared, share 1 zero: share 1 stays 00, share 0 follows S8(00).
    check("reset_so0", so_0, 8'h65);
    check("reset_so1", so_1, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_vec($sformatf("vec%0d_si%02h_m%02h_r%02h", i, vecs[i].si, vecs[i].mask, vecs[i].rnd),
              vecs[i].si, vecs[i].mask, vecs[i].rnd, vecs[i].exp);

    // Latency: 00 -> 01 under mask 5A, correct after the 4th posedge.
    run_vec("lat_pre", 8'h00, 8'h5A, 8'h96, 8'h65);
    run_vec("lat_post", 8'h01, 8'h5A, 8'h3E, 8'h4C);

    // Steady shares for si=00, mask 00, r=FF (hand-traced through the DOM gates).
    run_vec("steady_unshared", 8'h00, 8'h00, 8'hFF, 8'h65);
    check("steady_so0", so_0, 8'h90);
    check("steady_so1", so_1, 8'hF5);
    #2 rst_n = 1'b0;
    #1;
    check("async_clr_so0", so_0, 8'h65);
    check("async_clr_so1", so_1, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a computation, then restart from held inputs.
    drive(8'h02, 8'h3C, 8'hC3);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort_restart", so_0 ^ so_1, 8'h6A);

    // Back-to-back exhaustive sweep with fresh mask and randomness.
    sweep_err = n_errors;
    for (int i = 0; i < 256; i++)
      run_vec($sformatf("sweep_si%02h", i), 8'(i), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), s8_ref(8'(i)));
    if (n_errors == sweep_err) $display("Successful test!!");

    // Descending order so each input follows a different predecessor.
    for (int i = 255; i >= 0; i--)
      run_vec($sformatf("desc_si%02h", i), 8'(i), 8'($urandom_range(0, 255)),
              8'($urandom_range(0, 255)), s8_ref(8'(i)));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/skinny_sbox8_dom1_np_core.md
Name: skinny_sbox8_dom1_np_core

Overview:
- First-order DOM-masked (2-share) implementation of the SKINNY-128 8-bit S-box S8. It is non-pipelined: one masked input is processed at a time.
- It sits in the masked SKINNY-128-384+ round datapath, one instance per state byte.
- Unshared output (so_1 ^ so_0) equals S8(si_1 ^ si_0). This holds for any input mask and any fresh randomness.
- The unmasked S8 function is defined below. Verification uses it as a golden model; an unmasked lookup-table variant with ports (so, si) is a separate combinational companion block.

Parameters:
- none

Ports:
- clk    input   1  rising-edge clock
- rst_n  input   1  asynchronous, active-low reset
- so_1   output  8  output share 1
- so_0   output  8  output share 0
- si_1   input   8  input share 1
- si_0   input   8  input share 0
- r      input   8  fresh randomness; 2 bits per round

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.

Unmasked S8 on bits x7..x0:
- Round k (k = 0..3), nonlinear step:
  - x4 ^= NOR(x7, x6)
  - x0 ^= NOR(x3, x2)
- Rounds 0..2, bit permutation: (x7,x6,x5,x4,x3,x2,x1,x0) <- (x2,x1,x7,x6,x4,x0,x3,x5).
- Round 3: only swap x1 and x2.
- Reference values: S8(00)=65, S8(01)=4C, S8(02)=6A, S8(0F)=7B, S8(FF)=FF.

Masking:
- NOR(a,b) = (~a)&(~b). Complement is applied to share 0 of a and b only.
- Each NOR is a DOM-indep AND with inputs a0,a1 and b0,b1, randomness bit z:
  - c0 = a0&b0 ^ REG(a0&b1 ^ z)
  - c1 = a1&b1 ^ REG(a1&b0 ^ z)
- Inner-domain products are combinational. Only cross-domain terms, each already XORed with z, are registered.
- 2 gates per round, 4 rounds: 8 gates, 16 flip-flops total.
- Randomness map, round k:
  - gate on x4 uses r[2k]
  - gate on x0 uses r[2k+1]
- Linear operations (XOR into x4/x0, permutations) are share-wise and combinational.
- No share mixing outside the DOM cross terms. Cross terms always pass through a register before combination.

Timing:
- Hold si_0, si_1 and r stable. so_0/so_1 are valid after 4 rising clk edges: one register layer per round, settling in series.
- No valid/ready handshake. The caller holds inputs for ≥4 cycles.
- Outputs are sampled any time after the 4th edge while inputs remain stable.
- Outputs are combinational from registers plus inputs. They may glitch during the first 4 cycles after an input change.

Reset:
- rst_n=0 clears all 16 flip-flops to 0 immediately, without waiting for clk.
- Outputs during or just after reset are not meaningful. Outputs are valid again 4 edges after rst_n rises with stable inputs.
- Reset mid-computation aborts it. The computation restarts cleanly from the held inputs.

Boundary conditions:
- r = 00 and r = FF must both give correct unshared results.
- Mask = 00 must give correct results. So must si_1 = FF.
- Changing inputs before 4 edges gives undefined output. Thereafter the output is correct for the new inputs; no stale state is retained.

Test Plan:
- Exhaustive: for si in 00..FF, draw a random mask m and random r. Drive si_0 = si^m, si_1 = m, hold for 4 posedges. At the following negedge, require so_0^so_1 == S8(si), i.e. equal to the unmasked LUT. Print "Successful test!!" if all pass.
- Fixed vectors, mask 00, r 00: si 00->65, 01->4C, 02->6A, FF->FF.
- Randomness independence: si=3C with mask A5 under r = 00, 55, AA, FF. The unshared output must be identical each time; the individual shares may differ.
- Latency: change si from 00 to 01 (mask 5A). Unshared output must equal 4C after the 4th posedge. It is not required before that.
- Async reset: assert rst_n=0 mid-computation, between clock edges. Flops clear without a clock edge. Release, hold si=02 for 4 edges -> unshared 6A.
- Back-to-back: apply 256 inputs with fresh mask and r every 4 cycles. All outputs must be correct, with no dependence on the previous input.
